// File: rtl/dram_bank_ctrl_if.sv
// Request/response bus between the data-memory wrapper/datapath and dram_bank_ctrl.
// opt_dram_perr exists only when DRAM_PARITY_EN is defined.
interface dram_bank_ctrl_if #(
    parameter int CS_W      = 6,
    parameter int SUBADDR_W = 8,
    parameter int DATA_W    = 16
);
    logic                 ipt_wrp_to_dram_en_b;
    logic                 ipt_wrp_to_dram_rw;
    logic [CS_W-1:0]      ipt_wrp_to_dram_cs;
    logic [SUBADDR_W-1:0] ipt_wrp_to_dram_addr;
    logic [DATA_W-1:0]    ipt_dp_to_dram_wdata;
    logic [DATA_W-1:0]    opt_dram_rdata;
    logic                 opt_dram_rvalid;
    logic                 opt_dram_err;
    logic                 opt_dram_busy;
`ifdef DRAM_PARITY_EN
    logic                 opt_dram_perr;
`endif

    modport master (
        output ipt_wrp_to_dram_en_b, ipt_wrp_to_dram_rw, ipt_wrp_to_dram_cs,
        output ipt_wrp_to_dram_addr, ipt_dp_to_dram_wdata,
`ifdef DRAM_PARITY_EN
        input  opt_dram_perr,
`endif
        input  opt_dram_rdata, opt_dram_rvalid, opt_dram_err, opt_dram_busy
    );

    modport slave (
        input  ipt_wrp_to_dram_en_b, ipt_wrp_to_dram_rw, ipt_wrp_to_dram_cs,
        input  ipt_wrp_to_dram_addr, ipt_dp_to_dram_wdata,
`ifdef DRAM_PARITY_EN
        output opt_dram_perr,
`endif
        output opt_dram_rdata, opt_dram_rvalid, opt_dram_err, opt_dram_busy
    );
endinterface

// File: rtl/dram_bank_ctrl.sv
// Banked single-port data RAM with post-reset zero-fill; all state frozen while t_cs=0.
// Optional even parity per word and opt_dram_perr output under DRAM_PARITY_EN.
module dram_bank_ctrl #(
    parameter int NBANK     = 4,
    parameter int CS_W      = 6,
    parameter int SUBADDR_W = 8,
    parameter int DATA_W    = 16
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            t_cs,
    dram_bank_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << SUBADDR_W;
`ifdef DRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [SUBADDR_W:0] CNT_LAST = {1'b0, {SUBADDR_W{1'b1}}};
    localparam logic [SUBADDR_W:0] CNT_ONE  = 1;
    localparam logic [CS_W:0]      NBANK_C  = NBANK[CS_W:0];

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [SUBADDR_W:0] cnt, cnt_nxt;
    logic               init_we;
    logic               acc, rd_acc, wr_acc, cs_ok;
    logic [WORD_W-1:0]  rd_word, wr_word;
    logic [WORD_W-1:0]  mem [NBANK][DEPTH];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_we   = 1'b0;
        case (state)
            ST_INIT: begin
                if (t_cs) begin
                    init_we = 1'b1;
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == CNT_LAST)
                        state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        cs_ok  = ({1'b0, bus.ipt_wrp_to_dram_cs} < NBANK_C);
        acc    = (state == ST_RUN) && t_cs && !bus.ipt_wrp_to_dram_en_b;
        rd_acc = acc && bus.ipt_wrp_to_dram_rw;
        wr_acc = acc && !bus.ipt_wrp_to_dram_rw && cs_ok;
`ifdef DRAM_PARITY_EN
        wr_word = {^bus.ipt_dp_to_dram_wdata, bus.ipt_dp_to_dram_wdata};
`else
        wr_word = bus.ipt_dp_to_dram_wdata;
`endif
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned b = 0; b < NBANK; b++)
            if (bus.ipt_wrp_to_dram_cs == b[CS_W-1:0])
                rd_word = mem[b][bus.ipt_wrp_to_dram_addr];
    end

    // Init clear hits the same address in every bank at once; it and RUN writes are exclusive by state.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (init_we)
                mem[b][cnt[SUBADDR_W-1:0]] <= '0;
            else if (wr_acc && bus.ipt_wrp_to_dram_cs == b[CS_W-1:0])
                mem[b][bus.ipt_wrp_to_dram_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bus.opt_dram_rdata  <= '0;
            bus.opt_dram_rvalid <= 1'b0;
            bus.opt_dram_err    <= 1'b0;
`ifdef DRAM_PARITY_EN
            bus.opt_dram_perr   <= 1'b0;
`endif
        end else if (t_cs) begin
            bus.opt_dram_rvalid <= rd_acc;
            bus.opt_dram_err    <= acc && !cs_ok;
            if (rd_acc)
                bus.opt_dram_rdata <= cs_ok ? rd_word[DATA_W-1:0] : '0;
`ifdef DRAM_PARITY_EN
            // Even parity: a clean stored word (data + parity bit) XORs to zero.
            bus.opt_dram_perr   <= rd_acc && cs_ok && (^rd_word);
`endif
        end
    end

    always_comb bus.opt_dram_busy = (state == ST_INIT);

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Scoreboard bench for dram_bank_ctrl: randomized and directed accesses against an array model.
module tb_dram_bank_ctrl;
    localparam int NBANK = 4, CS_W = 6, SUBADDR_W = 8, DATA_W = 16, DEPTH = 256;

    logic clk = 1'b0, reset_b = 1'b0, t_cs = 1'b0;
    always #5 clk = ~clk;

    dram_bank_ctrl_if #(.CS_W(CS_W), .SUBADDR_W(SUBADDR_W), .DATA_W(DATA_W)) bus ();
    dram_bank_ctrl #(.NBANK(NBANK), .CS_W(CS_W), .SUBADDR_W(SUBADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_b(reset_b), .t_cs(t_cs), .bus(bus)
    );

    typedef struct { logic rvalid; logic [15:0] rdata; logic err; logic perr; } exp_t;
    exp_t        sb[$];
    logic [15:0] model  [NBANK][DEPTH];
    logic        poison [NBANK][DEPTH];
    bit          running = 1'b0;
    int          checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < DEPTH; a++) begin
                model[b][a]  = 16'h0;
                poison[b][a] = 1'b0;
            end
    endtask

    // One clock: drive inputs, record expected response, return at posedge+1.
    task automatic cycle(input logic tcs, input logic en_b, input logic rw,
                         input logic [CS_W-1:0] cs, input logic [7:0] addr, input logic [15:0] wd);
        exp_t e;
        t_cs                     = tcs;
        bus.ipt_wrp_to_dram_en_b = en_b;
        bus.ipt_wrp_to_dram_rw   = rw;
        bus.ipt_wrp_to_dram_cs   = cs;
        bus.ipt_wrp_to_dram_addr = addr;
        bus.ipt_dp_to_dram_wdata = wd;
        if (running && tcs && !en_b) begin
            if (cs < CS_W'(NBANK)) begin
                if (rw) begin
                    e = '{1'b1, model[cs[1:0]][addr], 1'b0, poison[cs[1:0]][addr]};
                    sb.push_back(e);
                end else begin
                    model[cs[1:0]][addr]  = wd;
                    poison[cs[1:0]][addr] = 1'b0;
                end
            end else begin
                e = '{rw, 16'h0, 1'b1, 1'b0};
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b0, 6'd0, 8'h00, 16'h0);
    endtask

    task automatic wait_init(input bit stalls);
        int   en_cnt;
        int   cyc;
        logic tc;
        en_cnt = 0;
        cyc    = 0;
        while (bus.opt_dram_busy === 1'b1 && cyc < 2000) begin
            tc = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(tc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 5)), 8'($urandom), 16'($urandom));
            if (tc) en_cnt++;
            cyc++;
        end
        check("init_enabled_cycles", en_cnt, 256);
        check("busy_after_init", bus.opt_dram_busy, 0);
    endtask

    initial begin : monitor
        logic was_en;
        exp_t e;
        forever begin
            @(posedge clk);
            was_en = t_cs && reset_b;
            @(negedge clk);
            if (was_en && (bus.opt_dram_rvalid || bus.opt_dram_err)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output rvalid=%0b err=%0b required=none",
                             bus.opt_dram_rvalid, bus.opt_dram_err);
                end else begin
                    e = sb.pop_front();
                    check("mon_rvalid", bus.opt_dram_rvalid, e.rvalid);
                    check("mon_err", bus.opt_dram_err, e.err);
                    if (e.rvalid) check("mon_rdata", bus.opt_dram_rdata, e.rdata);
`ifdef DRAM_PARITY_EN
                    check("mon_perr", bus.opt_dram_perr, e.perr);
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [CS_W-1:0] c;
        logic [7:0]      a;
        bus.ipt_wrp_to_dram_en_b = 1'b1;
        bus.ipt_wrp_to_dram_rw   = 1'b0;
        bus.ipt_wrp_to_dram_cs   = '0;
        bus.ipt_wrp_to_dram_addr = '0;
        bus.ipt_dp_to_dram_wdata = '0;
        t_cs = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", bus.opt_dram_rdata, 0);
        check("rst_rvalid", bus.opt_dram_rvalid, 0);
        check("rst_err", bus.opt_dram_err, 0);
        check("rst_busy", bus.opt_dram_busy, 1);
`ifdef DRAM_PARITY_EN
        check("rst_perr", bus.opt_dram_perr, 0);
`endif
        reset_b = 1'b1;
        wait_init(1'b0);
        running = 1'b1;

        cycle(1'b1, 1'b0, 1'b1, 6'd2, 8'h7F, 16'h0);
        check("rd_b2_7f_rvalid", bus.opt_dram_rvalid, 1);
        check("rd_b2_7f_rdata", bus.opt_dram_rdata, 16'h0000);

        cycle(1'b1, 1'b0, 1'b0, 6'd1, 8'h10, 16'hBEEF);
        cycle(1'b1, 1'b0, 1'b1, 6'd1, 8'h10, 16'h0);
        check("wr_rd_beef", bus.opt_dram_rdata, 16'hBEEF);
        cycle(1'b1, 1'b0, 1'b1, 6'd0, 8'h10, 16'h0);
        check("rd_b0_10", bus.opt_dram_rdata, 16'h0000);

        cycle(1'b1, 1'b0, 1'b0, 6'd3, 8'hFF, 16'h5A5A);
        cycle(1'b1, 1'b0, 1'b1, 6'd3, 8'hFF, 16'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'd0, 8'h10, 16'hFFFF);
            check("stall_rvalid", bus.opt_dram_rvalid, 1);
            check("stall_rdata", bus.opt_dram_rdata, 16'h5A5A);
        end
        idle();
        check("idle_rvalid", bus.opt_dram_rvalid, 0);
        check("idle_rdata_hold", bus.opt_dram_rdata, 16'h5A5A);

        cycle(1'b1, 1'b0, 1'b0, 6'd5, 8'h10, 16'h1234);
        check("oor_wr_err", bus.opt_dram_err, 1);
        check("oor_wr_rvalid", bus.opt_dram_rvalid, 0);
        cycle(1'b1, 1'b0, 1'b1, 6'd5, 8'h10, 16'h0);
        check("oor_rd_err", bus.opt_dram_err, 1);
        check("oor_rd_rdata", bus.opt_dram_rdata, 0);
        idle();
        check("oor_err_drop", bus.opt_dram_err, 0);
        for (int b = 0; b < NBANK; b++)
            cycle(1'b1, 1'b0, 1'b1, 6'(b), 8'h10, 16'h0);

        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 7) == 0) ? 6'(4 + $urandom_range(0, 59)) : 6'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h10 + $urandom_range(0, 7));
            cycle(1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), c, a, 16'($urandom));
        end
        idle();

        cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h01, 16'hAAAA);
        cycle(1'b1, 1'b0, 1'b1, 6'd0, 8'h01, 16'h0);
        check("pre_reset_aaaa", bus.opt_dram_rdata, 16'hAAAA);
        idle();
        running = 1'b0;
        reset_b = 1'b0;
        #1;
        check("mid_reset_busy", bus.opt_dram_busy, 1);
        check("mid_reset_rdata", bus.opt_dram_rdata, 0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        model_clear();
        wait_init(1'b1);
        running = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 6'd0, 8'h01, 16'h0);
        check("post_reset_cleared", bus.opt_dram_rdata, 16'h0000);

`ifdef DRAM_PARITY_EN
        cycle(1'b1, 1'b0, 1'b0, 6'd2, 8'h20, 16'h0F0F);
        cycle(1'b1, 1'b0, 1'b1, 6'd2, 8'h20, 16'h0);
        dut.mem[2][8'h20][3] = ~dut.mem[2][8'h20][3];
        model[2][8'h20]  = 16'h0F07;
        poison[2][8'h20] = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 6'd2, 8'h20, 16'h0);
        check("perr_flipped", bus.opt_dram_perr, 1);
        cycle(1'b1, 1'b0, 1'b1, 6'd1, 8'h10, 16'h0);
        check("perr_clean", bus.opt_dram_perr, 0);
`endif
        idle();
        idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
